// File: rtl/patdet_param.sv
// Serial pattern detector with a loadable pattern register, optional overlapping
// detection and a saturating match counter.
module patdet_param #(
    parameter int                 PAT_LEN  = 4,
    parameter logic [PAT_LEN-1:0] PAT_INIT = 4'b1110,
    parameter int                 OVERLAP  = 1,
    parameter int                 CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               data,
    input  logic               load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int FW = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] pattern;
    logic [PAT_LEN-2:0] history;
    logic [FW-1:0]      fill;
    logic [PAT_LEN-1:0] window;
    logic               accept;
    logic               full;
    logic               detect;

    // The window is the candidate match: oldest history bit lines up with pattern MSB.
    assign window = {history, data};
    assign accept = en & ~load;
    assign full   = (fill == FILL_FULL);
    assign detect = accept & full & (window == pattern);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern   <= PAT_INIT;
            history   <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            match <= detect;

            if (load) begin
                pattern <= pat_in;
                fill    <= '0;
            end else if (accept) begin
                history <= window[PAT_LEN-2:0];
                if (detect && (OVERLAP == 0))
                    fill <= '0;
                else if (!full)
                    fill <= fill + FW'(1);
            end

            // Clear takes priority over a coincident detect.
            if (cnt_clr)
                match_cnt <= '0;
            else if (detect && (match_cnt != {CNT_W{1'b1}}))
                match_cnt <= match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_patdet_param.sv
// Bench for patdet_param: three instances (default, non-overlapping, 2-bit counter)
// share stimulus and are checked against a queue-based reference model.
module tb_patdet_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       data = 1'b0;
    logic       load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       cnt_clr = 1'b0;

    logic       m0, m1, m2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    patdet_param u0 (.clk(clk), .rst(rst), .en(en), .data(data), .load(load),
                     .pat_in(pat_in), .cnt_clr(cnt_clr), .match(m0), .match_cnt(c0));
    patdet_param #(.PAT_LEN(4), .PAT_INIT(4'b1110), .OVERLAP(0), .CNT_W(8)) u1 (
                     .clk(clk), .rst(rst), .en(en), .data(data), .load(load),
                     .pat_in(pat_in), .cnt_clr(cnt_clr), .match(m1), .match_cnt(c1));
    patdet_param #(.PAT_LEN(4), .PAT_INIT(4'b1110), .OVERLAP(1), .CNT_W(2)) u2 (
                     .clk(clk), .rst(rst), .en(en), .data(data), .load(load),
                     .pat_in(pat_in), .cnt_clr(cnt_clr), .match(m2), .match_cnt(c2));

    // Reference model: accepted-bit queue plus, per instance, the number of
    // bits accepted since the last reset/load/non-overlap match.
    int         ov[3]   = '{1, 0, 1};
    int         cmax[3] = '{255, 255, 3};
    int         fresh[3];
    int         mcnt[3];
    int         mmatch[3];
    logic [3:0] mpat[3];
    bit         acc_q[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            fresh[m]  = 0;
            mcnt[m]   = 0;
            mmatch[m] = 0;
            mpat[m]   = 4'b1110;
        end
    endtask

    task automatic model_step(input bit e, input bit d, input bit l, input logic [3:0] p,
                              input bit c);
        bit         accept;
        logic [3:0] last;
        int         n;
        accept = e && !l;
        last   = 4'b0000;
        if (accept) begin
            acc_q.push_back(d);
            if (acc_q.size() > 8) void'(acc_q.pop_front());
        end
        n = acc_q.size();
        if (n >= 4) last = {acc_q[n-4], acc_q[n-3], acc_q[n-2], acc_q[n-1]};
        for (int m = 0; m < 3; m++) begin
            mmatch[m] = 0;
            if (l) begin
                mpat[m]  = p;
                fresh[m] = 0;
            end else if (accept) begin
                fresh[m]++;
                if (fresh[m] >= 4 && last == mpat[m]) begin
                    mmatch[m] = 1;
                    if (mcnt[m] < cmax[m]) mcnt[m]++;
                    if (ov[m] == 0) fresh[m] = 0;
                end
            end
            if (c) mcnt[m] = 0;
        end
    endtask

    task automatic check_all();
        chk("u0.match", int'(m0), mmatch[0]);
        chk("u0.cnt",   int'(c0), mcnt[0]);
        chk("u1.match", int'(m1), mmatch[1]);
        chk("u1.cnt",   int'(c1), mcnt[1]);
        chk("u2.match", int'(m2), mmatch[2]);
        chk("u2.cnt",   int'(c2), mcnt[2]);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs checked at the same point.
    task automatic cyc(input bit e, input bit d, input bit l = 1'b0,
                       input logic [3:0] p = 4'b0000, input bit c = 1'b0);
        en = e; data = d; load = l; pat_in = p; cnt_clr = c;
        model_step(e, d, l, p, c);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Reset pulse lands between clock edges; outputs must clear without a clock.
    task automatic rst_pulse();
        en = 1'b0; load = 1'b0; cnt_clr = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #2;
        rst = 1'b0;
    endtask

    task automatic feed(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) cyc(1'b1, bits[i]);
    endtask

    typedef struct {
        bit en;
        bit data;
        bit exp_match;
        int exp_cnt;
    } vec_t;
    vec_t tbl[9];

    initial begin
        // 1110 detected, then 1,1,(en=0 data 0),1,0 completes 1110 again.
        tbl[0] = '{1, 1, 0, 0};
        tbl[1] = '{1, 1, 0, 0};
        tbl[2] = '{1, 1, 0, 0};
        tbl[3] = '{1, 0, 1, 1};
        tbl[4] = '{1, 1, 0, 1};
        tbl[5] = '{1, 1, 0, 1};
        tbl[6] = '{0, 0, 0, 1};
        tbl[7] = '{1, 1, 0, 1};
        tbl[8] = '{1, 0, 1, 2};

        #3;
        model_reset();
        check_all();
        #3;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].en, tbl[i].data);
            chk("tbl.match", int'(m0), int'(tbl[i].exp_match));
            chk("tbl.cnt", int'(c0), tbl[i].exp_cnt);
        end

        // Pattern 1010: overlapping hits after bits 4,6,8; non-overlapping after 4,8.
        rst_pulse();
        cyc(1'b1, 1'b0, 1'b1, 4'b1010);
        chk("load.no_match", int'(m0), 0);
        feed(4'b1010);
        chk("ov1.first", int'(m0), 1);
        chk("ov0.first", int'(m1), 1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        chk("ov1.second", int'(m0), 1);
        chk("ov0.skip", int'(m1), 0);
        chk("ov1.cnt6", int'(c0), 2);
        chk("ov0.cnt6", int'(c1), 1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        chk("ov0.second", int'(m1), 1);
        chk("ov0.cnt8", int'(c1), 2);

        // 2-bit counter saturates; clear wins over a coincident detect.
        rst_pulse();
        for (int r = 0; r < 5; r++) begin
            feed(4'b1110);
            chk("sat.cnt", int'(c2), (r < 3) ? r + 1 : 3);
        end
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
        chk("clr.match", int'(m2), 1);
        chk("clr.cnt", int'(c2), 0);

        // Mid-sequence reset discards progress.
        rst_pulse();
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        rst_pulse();
        cyc(1'b1, 1'b0);
        chk("rst.no_match", int'(m0), 0);
        chk("rst.cnt", int'(c0), 0);
        feed(4'b1110);
        chk("rst.after", int'(m0), 1);

        // Load discards its data bit and restarts the fill.
        rst_pulse();
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 4'b1110);
        chk("load.edge", int'(m0), 0);
        cyc(1'b1, 1'b0);
        chk("load.fill0", int'(m0), 0);
        feed(4'b1110);
        chk("load.after", int'(m0), 1);

        // Randomized traffic against the model.
        rst_pulse();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_pulse();
            end else begin
                cyc(($urandom_range(0, 9) < 8), 1'($urandom),
                    ($urandom_range(0, 49) == 0), 4'($urandom),
                    ($urandom_range(0, 39) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
